// File: rtl/crop_pkg.sv
// Shared types for the crop window controller: FSM states and latched window corners.
package crop_pkg;

    localparam int CROP_COORD_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } crop_state_t;

    typedef struct packed {
        logic [CROP_COORD_W-1:0] x1;
        logic [CROP_COORD_W-1:0] x2;
        logic [CROP_COORD_W-1:0] y1;
        logic [CROP_COORD_W-1:0] y2;
    } crop_win_t;

    function automatic logic win_hit(input crop_win_t w,
                                     input logic [CROP_COORD_W-1:0] col,
                                     input logic [CROP_COORD_W-1:0] row);
        return (col >= w.x1) && (col <= w.x2) && (row >= w.y1) && (row <= w.y2);
    endfunction

endpackage

// File: rtl/crop_raster_cnt.sv
// Raster-order row/column position of the next input pixel, with last-pixel flag.
module crop_raster_cnt #(
    parameter int ROWS = 512,
    parameter int COLS = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    adv,
    output logic [$clog2(ROWS)-1:0] row,
    output logic [$clog2(COLS)-1:0] col,
    output logic                    last
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic col_end;
    logic row_end;

    assign col_end = (col == CW'(COLS - 1));
    assign row_end = (row == RW'(ROWS - 1));
    assign last    = col_end && row_end;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/crop_window_ctrl.sv
// Crops a raster pixel stream to a configured inclusive window.
// Optional CROP_BOUNDS_CHECK_EN rejects malformed windows with a cfg_err pulse.
module crop_window_ctrl
    import crop_pkg::*;
#(
    parameter int ROWS  = 512,
    parameter int COLS  = 512,
    parameter int PIX_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [$clog2(COLS)-1:0] cfg_x1,
    input  logic [$clog2(COLS)-1:0] cfg_x2,
    input  logic [$clog2(ROWS)-1:0] cfg_y1,
    input  logic [$clog2(ROWS)-1:0] cfg_y2,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [PIX_W-1:0]        s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [PIX_W-1:0]        m_data,
    output logic                    m_eol,
    output logic                    m_eof,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    crop_state_t      state;
    crop_win_t        win;
    crop_win_t        cfg_win;
    logic [RW-1:0]    row;
    logic [CW-1:0]    col;
    logic             last_pix;
    logic             in_win;
    logic             s_fire;
    logic             cfg_fire;
    logic             cfg_bad;
    logic             cnt_clr;
    logic             vld_p0;
    logic             eol_p0;
    logic             eof_p0;
    logic [PIX_W-1:0] data_p0;

    assign cfg_win = '{x1: CROP_COORD_W'(cfg_x1), x2: CROP_COORD_W'(cfg_x2),
                       y1: CROP_COORD_W'(cfg_y1), y2: CROP_COORD_W'(cfg_y2)};
    assign in_win    = win_hit(win, CROP_COORD_W'(col), CROP_COORD_W'(row));
    assign cfg_ready = (state == IDLE);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign s_fire    = s_valid && s_ready;

`ifdef CROP_BOUNDS_CHECK_EN
    assign cfg_bad = (cfg_win.x1 > cfg_win.x2) || (cfg_win.y1 > cfg_win.y2) ||
                     (cfg_win.x2 >= CROP_COORD_W'(COLS)) || (cfg_win.y2 >= CROP_COORD_W'(ROWS));
`else
    assign cfg_bad = 1'b0;
`endif

    assign cnt_clr = cfg_fire && !cfg_bad;

    // Out-of-window pixels are always drained; in-window ones wait for output space.
    always_comb begin
        s_ready = 1'b0;
        if (state == STREAM) begin
            s_ready = in_win ? (!vld_p0 || m_ready) : 1'b1;
        end
    end

    crop_raster_cnt #(
        .ROWS(ROWS),
        .COLS(COLS)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .adv  (s_fire),
        .row  (row),
        .col  (col),
        .last (last_pix)
    );

    always_ff @(posedge clk) begin
        if (cfg_fire) begin
            win <= cfg_win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= cfg_fire && cfg_bad;
            case (state)
                IDLE: begin
                    if (cnt_clr) begin
                        state <= STREAM;
                        busy  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (s_fire && last_pix) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (!vld_p0 || m_ready) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // p0: output register stage, held while the sink stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            eol_p0 <= 1'b0;
            eof_p0 <= 1'b0;
        end else if (s_fire && in_win) begin
            vld_p0 <= 1'b1;
            eol_p0 <= (CROP_COORD_W'(col) == win.x2);
            eof_p0 <= (CROP_COORD_W'(col) == win.x2) && (CROP_COORD_W'(row) == win.y2);
        end else if (m_ready) begin
            vld_p0 <= 1'b0;
            eol_p0 <= 1'b0;
            eof_p0 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (s_fire && in_win) begin
            data_p0 <= s_data;
        end
    end

    assign m_valid = vld_p0;
    assign m_data  = data_p0;
    assign m_eol   = eol_p0;
    assign m_eof   = eof_p0;

endmodule

// File: tb/tb_crop_window_ctrl.sv
// Scoreboard bench for crop_window_ctrl on an 8x8 frame with s_data = row*8+col.
module tb_crop_window_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_x1, cfg_x2, cfg_y1, cfg_y2;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_eol, m_eof;
    logic       busy, done, cfg_err;

    typedef struct {
        logic [7:0] d;
        logic       eol;
        logic       eof;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   beat_cnt = 0;
    int   win_a[9] = '{18, 19, 20, 26, 27, 28, 34, 35, 36};

    always #5 clk = ~clk;

    crop_window_ctrl #(.ROWS(8), .COLS(8), .PIX_W(8)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_x1(cfg_x1), .cfg_x2(cfg_x2), .cfg_y1(cfg_y1), .cfg_y2(cfg_y2),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_eol(m_eol), .m_eof(m_eof),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle, pops the scoreboard on every output transfer.
    initial begin
        logic        stall_prev;
        logic [10:0] held;
        exp_t        e;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            #2;
            if (done) done_cnt++;
            if (cfg_err) err_cnt++;
            if (stall_prev) chk("stall_hold", {m_valid, m_eol, m_eof, m_data}, held);
            if (m_valid && m_ready) begin
                beat_cnt++;
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_beat: got data %0d, expected no beat", m_data);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", m_data, e.d);
                    chk("beat_eol", m_eol, e.eol);
                    chk("beat_eof", m_eof, e.eof);
                end
            end
            stall_prev = m_valid && !m_ready && !rst;
            held = {m_valid, m_eol, m_eof, m_data};
        end
    end

    task automatic push_exp(input int d, input bit eol, input bit eof);
        exp_t e;
        e.d = d[7:0];
        e.eol = eol;
        e.eof = eof;
        sb.push_back(e);
    endtask

    task automatic push_win_a();
        for (int i = 0; i < 9; i++) push_exp(win_a[i], (i % 3) == 2, i == 8);
    endtask

    task automatic push_full(input int n);
        for (int i = 0; i < n; i++) push_exp(i, (i % 8) == 7, i == 63);
    endtask

    task automatic do_cfg(input int x1, input int y1, input int x2, input int y2);
        @(negedge clk);
        done_cnt = 0;
        err_cnt = 0;
        beat_cnt = 0;
        cfg_x1 = x1[2:0];
        cfg_y1 = y1[2:0];
        cfg_x2 = x2[2:0];
        cfg_y2 = y2[2:0];
        cfg_valid = 1'b1;
        #1 chk("cfg_ready_idle", cfg_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic stream(input int n_beats, input bit toggle, input bit poke);
        int pix;
        bit acc;
        pix = 0;
        for (int cyc = 0; cyc < 2000 && pix < n_beats; cyc++) begin
            @(negedge clk);
            m_ready = toggle ? ~m_ready : 1'b1;
            s_valid = 1'b1;
            s_data = pix[7:0];
            if (poke) begin
                cfg_valid = 1'b1;
                cfg_x1 = 3'd0;
                cfg_y1 = 3'd0;
                cfg_x2 = 3'd7;
                cfg_y2 = 3'd7;
            end
            #1;
            acc = s_ready;
            if (poke && cyc == 3) chk("cfg_ready_stream", cfg_ready, 0);
            @(posedge clk);
            if (acc) pix++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        cfg_valid = 1'b0;
        m_ready = 1'b1;
        chk("inputs_consumed", pix, n_beats);
    endtask

    task automatic finish_frame(input int exp_beats);
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        #3;
        chk("busy_after_frame", busy, 0);
        chk("sb_empty", sb.size(), 0);
        chk("beat_count", beat_cnt, exp_beats);
        chk("done_pulses", done_cnt, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cfg_valid = 1'b0;
        cfg_x1 = '0; cfg_x2 = '0; cfg_y1 = '0; cfg_y2 = '0;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_flags", {m_eol, m_eof, done, cfg_err}, 0);
        rst = 1'b0;

        do_cfg(2, 2, 4, 4);
        push_win_a();
        stream(64, 1'b0, 1'b0);
        finish_frame(9);

        do_cfg(2, 2, 4, 4);
        push_win_a();
        stream(64, 1'b1, 1'b0);
        finish_frame(9);

        do_cfg(0, 0, 7, 7);
        push_full(64);
        stream(64, 1'b0, 1'b0);
        finish_frame(64);

`ifdef CROP_BOUNDS_CHECK_EN
        do_cfg(5, 1, 3, 6);
        repeat (3) @(negedge clk);
        #3;
        chk("bad_cfg_err_pulses", err_cnt, 1);
        chk("bad_cfg_busy", busy, 0);
        chk("bad_cfg_ready", cfg_ready, 1);
        chk("bad_cfg_no_done", done_cnt, 0);
`else
        do_cfg(5, 1, 3, 6);
        stream(64, 1'b0, 1'b0);
        finish_frame(0);
        chk("empty_win_no_err", err_cnt, 0);
`endif

        do_cfg(0, 0, 7, 7);
        push_full(20);
        stream(20, 1'b0, 1'b0);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cfg_ready", cfg_ready, 1);
        chk("midrst_s_ready", s_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_sb_empty", sb.size(), 0);

        do_cfg(0, 0, 7, 7);
        push_full(64);
        stream(64, 1'b0, 1'b0);
        finish_frame(64);

        do_cfg(2, 2, 4, 4);
        push_win_a();
        stream(64, 1'b0, 1'b1);
        finish_frame(9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
